// File: rtl/sc_mul_sched.sv
// Scheduler that shares one stochastic AND multiplier between two requesters.
// A round-robin arbiter picks a request, the operands are loaded into the
// multiplier, the ones on mul_oC are counted over 2^DATAWD cycles, and the
// count is returned with the id of the requester that was served.
//
// state | meaning
// IDLE  | waiting for a request; arbiter drives req_ready
// LOAD  | one cycle: load multiplier operand buffers, restart both RNGs
// RUN   | 2^DATAWD cycles: accumulate mul_oC into the ones counter
// DONE  | result offered on res_*; held until res_ready
module sc_mul_sched #(
    parameter int DATAWD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATAWD-1:0] req_a0,
    input  logic [DATAWD-1:0] req_b0,
    input  logic [DATAWD-1:0] req_a1,
    input  logic [DATAWD-1:0] req_b1,
    output logic [DATAWD-1:0] mul_a,
    output logic [DATAWD-1:0] mul_b,
    output logic              mul_loadA,
    output logic              mul_loadB,
    output logic              rng_clr,
    input  logic              mul_oC,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATAWD:0]   res_data,
    output logic              res_id,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic              ptr;
    logic              grant_id;
    logic              accept;
    logic [DATAWD-1:0] cap_a;
    logic [DATAWD-1:0] cap_b;
    logic              cap_id;
    logic [DATAWD:0]   ones;
    logic [DATAWD-1:0] cyc;

    // Round-robin grant: the pointer only matters when both requesters are valid.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ptr;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
        req_ready = 2'b00;
        if (state == S_IDLE && req_valid != 2'b00) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);
    end

    // Sequencer: state, arbitration pointer and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= 1'b0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_id <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_a  <= grant_id ? req_a1 : req_a0;
                        cap_b  <= grant_id ? req_b1 : req_b0;
                        cap_id <= grant_id;
                        ptr    <= ~grant_id;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (cyc == '1) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Ones counter and run-length counter; one bit wider ones count so a
    // full stream of ones does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            cyc  <= '0;
        end else if (state == S_LOAD) begin
            ones <= '0;
            cyc  <= '0;
        end else if (state == S_RUN) begin
            ones <= ones + (DATAWD+1)'(mul_oC);
            cyc  <= cyc + DATAWD'(1);
        end
    end

    // Outputs decoded from state; operands stay on the captured values.
    always_comb begin
        mul_a     = cap_a;
        mul_b     = cap_b;
        mul_loadA = (state == S_LOAD);
        mul_loadB = (state == S_LOAD);
        rng_clr   = (state == S_LOAD);
        res_valid = (state == S_DONE);
        res_data  = (state == S_DONE) ? ones : '0;
        res_id    = cap_id;
        busy      = (state != S_IDLE);
    end

endmodule

// File: tb/tb_sc_mul_sched.sv
// Bench for sc_mul_sched: a cycle-age model of each transaction checks all
// outputs every cycle, and directed scenarios pin results with literals.
module tb_sc_mul_sched;

    localparam int W      = 8;
    localparam int RUNLEN = 256;
    localparam int DONE_AGE = RUNLEN + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [W-1:0] mul_a, mul_b;
    logic         mul_loadA, mul_loadB, rng_clr;
    logic         mul_oC;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W:0]   res_data;
    logic         res_id;
    logic         busy;

    int   oc_mode = 1;      // 0: constant 0, 1: constant 1, 2: alternating
    logic oc_tog = 1'b0;

    sc_mul_sched #(.DATAWD(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_loadA(mul_loadA), .mul_loadB(mul_loadB), .rng_clr(rng_clr),
        .mul_oC(mul_oC),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        oc_tog = ~oc_tog;
    end

    assign mul_oC = (oc_mode == 1) || (oc_mode == 2 && oc_tog);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Model: age counts cycles since the handshake cycle (0 = idle).
    int           age = 0;
    int           ptr_m = 0;
    logic [W-1:0] cap_a_m = '0, cap_b_m = '0;
    int           cap_id_m = 0;
    int           ones_m = 0;
    int           cyc = 0;
    int           hs_cyc = 0;
    int           hs_count = 0;
    logic         prev_rv = 1'b0;
    int           res_ids[$];
    int           res_vals[$];
    int           lats[$];

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        int g;
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_data", 32'(res_data), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_strobes", 32'({mul_loadA, mul_loadB, rng_clr}), 0);
            chk("rst_mul_a", 32'(mul_a), 0);
            chk("rst_mul_b", 32'(mul_b), 0);
            age = 0; ptr_m = 0; cap_a_m = '0; cap_b_m = '0; cap_id_m = 0;
            ones_m = 0; prev_rv = 1'b0;
        end else begin
            exp_rdy = 2'b00;
            if (age == 0) begin
                if (req_valid == 2'b11) exp_rdy = (ptr_m == 1) ? 2'b10 : 2'b01;
                else                    exp_rdy = req_valid;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(age != 0));
            chk("load_strobes", 32'({mul_loadA, mul_loadB, rng_clr}), (age == 1) ? 7 : 0);
            chk("mul_a", 32'(mul_a), 32'(cap_a_m));
            chk("mul_b", 32'(mul_b), 32'(cap_b_m));
            chk("res_valid", 32'(res_valid), 32'(age >= DONE_AGE));
            if (age >= DONE_AGE) begin
                chk("res_data", 32'(res_data), ones_m);
                chk("res_id", 32'(res_id), cap_id_m);
            end
            if (res_valid && !prev_rv) lats.push_back(cyc - hs_cyc);
            prev_rv = res_valid;
            if (age == 0) begin
                if (exp_rdy != 2'b00) begin
                    g = exp_rdy[1] ? 1 : 0;
                    cap_a_m  = g ? req_a1 : req_a0;
                    cap_b_m  = g ? req_b1 : req_b0;
                    cap_id_m = g;
                    ptr_m    = 1 - g;
                    ones_m   = 0;
                    age      = 1;
                    hs_cyc   = cyc;
                    hs_count++;
                end
            end else if (age >= DONE_AGE) begin
                if (res_ready) begin
                    res_ids.push_back(cap_id_m);
                    res_vals.push_back(ones_m);
                    age = 0;
                end
            end else begin
                if (age >= 2) ones_m += int'(mul_oC);
                age++;
            end
        end
    end

    function automatic int q_get(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_hs(input int n, input string name);
        int k = 0;
        while (hs_count < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 32'(hs_count >= n), 1);
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (res_vals.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 32'(res_vals.size() >= n), 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int sd;
        int sid;
        int k;

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_busy_lit", 32'(busy), 0);
        chk("reset_res_valid_lit", 32'(res_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A: all-ones stream, requester 0.
        oc_mode = 1;
        req_a0 = 8'd200; req_b0 = 8'd100;
        req_valid = 2'b01;
        wait_hs(1, "A_hs_timeout");
        req_valid = 2'b00;
        wait_results(1, "A_res_timeout");
        chk("A_latency", q_get(lats, 0), 258);
        chk("A_data", q_get(res_vals, 0), 256);
        chk("A_id", q_get(res_ids, 0), 0);

        // B: all-zero stream; requester 0 alone wins although pointer is at 1.
        oc_mode = 0;
        req_a0 = 8'd3; req_b0 = 8'd9;
        req_valid = 2'b01;
        wait_hs(2, "B_hs_timeout");
        req_valid = 2'b00;
        wait_results(2, "B_res_timeout");
        chk("B_data", q_get(res_vals, 1), 0);
        chk("B_id", q_get(res_ids, 1), 0);

        pulse_reset();

        // D: both requesters held valid over three transactions.
        oc_mode = 1;
        req_a0 = 8'd10; req_b0 = 8'd20; req_a1 = 8'd30; req_b1 = 8'd40;
        n0 = hs_count;
        req_valid = 2'b11;
        wait_hs(n0 + 3, "D_hs_timeout");
        req_valid = 2'b00;
        wait_results(5, "D_res_timeout");
        chk("D_id0", q_get(res_ids, 2), 0);
        chk("D_id1", q_get(res_ids, 3), 1);
        chk("D_id2", q_get(res_ids, 4), 0);
        chk("D_data", q_get(res_vals, 3), 256);

        // E: alternating stream, requester 1, operand change mid-run,
        // result held back for 10 cycles while requester 0 waits.
        oc_mode = 2;
        res_ready = 1'b0;
        req_a1 = 8'd61; req_b1 = 8'd62;
        n0 = hs_count;
        req_valid = 2'b10;
        wait_hs(n0 + 1, "E_hs_timeout");
        req_valid = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        req_a1 = 8'hAA; req_b1 = 8'h55;
        req_a0 = 8'hCC;
        k = 0;
        while (!res_valid && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("E_done_timeout", 32'(res_valid), 1);
        sd  = int'(res_data);
        sid = int'(res_id);
        chk("E_data_lit", sd, 128);
        chk("E_id_lit", sid, 1);
        req_a0 = 8'd77; req_b0 = 8'd11;
        req_valid = 2'b01;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("E_hold_valid", 32'(res_valid), 1);
            chk("E_hold_data", 32'(res_data), 128);
            chk("E_hold_id", 32'(res_id), 1);
            chk("E_hold_ready", 32'(req_ready), 0);
            chk("E_hold_busy", 32'(busy), 1);
        end
        chk("E_no_early_result", res_vals.size(), 5);
        res_ready = 1'b1;
        oc_mode = 1;

        // F: the waiting request is taken next; operand change and reset mid-run.
        n0 = hs_count;
        wait_hs(n0 + 1, "F_hs_timeout");
        req_valid = 2'b00;
        chk("E_res_count", res_vals.size(), 6);
        chk("E_data", q_get(res_vals, 5), 128);
        chk("E_id", q_get(res_ids, 5), 1);
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        req_a0 = 8'd250;
        chk("F_mul_a_held", 32'(mul_a), 77);
        repeat (30) @(posedge clk);
        #1;
        chk("F_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("F_rst_busy", 32'(busy), 0);
        chk("F_rst_res_valid", 32'(res_valid), 0);
        chk("F_rst_strobes", 32'({mul_loadA, mul_loadB, rng_clr}), 0);
        chk("F_rst_mul_a", 32'(mul_a), 0);
        chk("F_rst_mul_b", 32'(mul_b), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // G: after reset the pointer is back at requester 0.
        req_a0 = 8'd5; req_b0 = 8'd6; req_a1 = 8'd7; req_b1 = 8'd8;
        n0 = hs_count;
        req_valid = 2'b11;
        wait_hs(n0 + 1, "G_hs_timeout");
        req_valid = 2'b00;
        wait_results(7, "G_res_timeout");
        chk("F_no_result", res_vals.size(), 7);
        chk("G_id", q_get(res_ids, 6), 0);
        chk("G_data", q_get(res_vals, 6), 256);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
